// File: rtl/alu_arith_pipe.sv
// alu_arith_pipe: two-stage valid/ready arithmetic/compare ALU for execute.
// S1 registers operands, S2 registers result, carry/ovf and sticky overflow.
module alu_arith_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int M = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SEQ = 3'd2;
  localparam logic [2:0] OP_SNE = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_SGT = 3'd5;
  localparam logic [2:0] OP_SLE = 3'd6;
  localparam logic [2:0] OP_SGE = 3'd7;

  logic         r_s1_valid;
  logic [M:0]   r_s1_a;
  logic [M:0]   r_s1_b;
  logic [2:0]   r_s1_op;
  logic         r_s1_signed;

  logic         r_s2_valid;
  logic [M:0]   r_data;
  logic         r_carry;
  logic         r_ovf;
  logic         r_sticky;

  logic         w_s2_load;
  logic         w_s1_adv;
  logic         w_in_fire;
  logic         w_sub;
  logic         w_arith;
  logic [M:0]   w_bx;
  logic [M:0]   w_sum;
  logic         w_cout;
  logic         w_ovf;
  logic         w_eq;
  logic         w_lt;
  logic         w_bit;
  logic [M:0]   w_res;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_in_fire = in_valid && in_ready;

  // Every op but ADD subtracts; compares reuse the subtractor.
  assign w_sub   = (r_s1_op != OP_ADD);
  assign w_arith = (r_s1_op[2:1] == 2'b00);
  assign w_bx    = w_sub ? ~r_s1_b : r_s1_b;

  assign {w_cout, w_sum} = {1'b0, r_s1_a}
                         + {1'b0, w_bx}
                         + {{WIDTH{1'b0}}, w_sub};

  assign w_ovf = (r_s1_a[M] == w_bx[M])
              && (w_sum[M] != r_s1_a[M]);

  assign w_eq = (r_s1_a == r_s1_b);
  assign w_lt = r_s1_signed ? (w_sum[M] ^ w_ovf)
                            : ~w_cout;

  always_comb begin
    w_bit = 1'b0;
    unique case (r_s1_op)
      OP_ADD: w_bit = 1'b0;
      OP_SUB: w_bit = 1'b0;
      OP_SEQ: w_bit = w_eq;
      OP_SNE: w_bit = !w_eq;
      OP_SLT: w_bit = w_lt;
      OP_SGT: w_bit = !w_lt && !w_eq;
      OP_SLE: w_bit = w_lt || w_eq;
      OP_SGE: w_bit = !w_lt;
      default: w_bit = 1'b0;
    endcase
  end

  assign w_res = w_arith ? w_sum : {{M{1'b0}}, w_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_op     <= 3'd0;
      r_s1_signed <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid  <= 1'b1;
      r_s1_a      <= in_a;
      r_s1_b      <= in_b;
      r_s1_op     <= in_op;
      r_s1_signed <= in_signed;
    end else if (w_s1_adv) begin
      r_s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_data     <= '0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data  <= w_res;
        r_carry <= w_arith && w_cout;
        r_ovf   <= w_arith && w_ovf;
      end
    end
  end

  // A set in the same cycle as ovf_clr must win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_s1_adv && w_arith && w_ovf) begin
      r_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_data   = r_data;
  assign out_carry  = r_carry;
  assign out_ovf    = r_ovf;
  assign ovf_sticky = r_sticky;

endmodule
